// File: rtl/fir_sym_pkg.sv
// Shared types and helpers for the time-multiplexed symmetric FIR.
package fir_sym_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } fsm_t;

    // Default coefficients c[0..9] = {0,-1,0,2,2,-2,-5,0,12,24}, c[0] in the LSBs.
    localparam logic [59:0] COEF_INIT_DEF = {
        6'h18, 6'h0C, 6'h00, 6'h3B, 6'h3E,
        6'h02, 6'h02, 6'h00, 6'h3F, 6'h00
    };

    // Full-precision accumulator width: pre-add + coefficient + growth over H pairs.
    function automatic int unsigned acc_w(input int unsigned data_w,
                                          input int unsigned coef_w,
                                          input int unsigned taps);
        return data_w + 1 + coef_w + $clog2(taps / 2);
    endfunction

    // Arithmetic shift with round-half-up, then saturate to a signed out_w range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int unsigned       shift,
                                                     input int unsigned       out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (shift == 0) begin
            r = acc;
        end else begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample history shift register; tap i holds x[n-i] at bits [i*DATA_W +: DATA_W].
module fir_delay_line #(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned TAPS   = 20
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     shift_en_i,
    input  logic                     clear_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W*TAPS-1:0]   taps_o
);

    logic [DATA_W*TAPS-1:0] line_q;
    logic [DATA_W*TAPS-1:0] line_d;

    // Clear first so a coincident shift yields {data_i, 0, ...}.
    always_comb begin
        line_d = line_q;
        if (clear_i) begin
            line_d = '0;
        end
        if (shift_en_i) begin
            line_d = {line_d[DATA_W*(TAPS-1)-1:0], data_i};
        end
    end

    // History register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign taps_o = line_q;

endmodule

// File: rtl/fir_sym_tdm.sv
// Time-multiplexed symmetric FIR: NUM_MAC pre-add/multiply lanes swept over TAPS/2 pairs.
module fir_sym_tdm
    import fir_sym_pkg::*;
#(
    parameter int unsigned DATA_W    = 5,
    parameter int unsigned COEF_W    = 6,
    parameter int unsigned TAPS      = 20,
    parameter int unsigned NUM_MAC   = 2,
    parameter int unsigned OUT_W     = 5,
    parameter int unsigned OUT_SHIFT = 9,
    parameter logic [(TAPS/2)*COEF_W-1:0] COEF_INIT = COEF_INIT_DEF
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic signed [DATA_W-1:0]      data_in_i,
    input  logic                          clear_i,
    input  logic                          coef_load_i,
    input  logic [(TAPS/2)*COEF_W-1:0]    coef_in_i,
    output logic                          out_valid_o,
    output logic signed [OUT_W-1:0]       data_out_o
);

    localparam int unsigned H      = TAPS / 2;
    localparam int unsigned P      = H / NUM_MAC;
    localparam int unsigned PRE_W  = DATA_W + 1;
    localparam int unsigned PROD_W = PRE_W + COEF_W;
    localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int unsigned PASS_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned CV_W   = H * COEF_W;

    fsm_t                       state_q, state_d;
    logic [PASS_W-1:0]          pass_q, pass_d;
    logic [CV_W-1:0]            coef_q, coef_d;
    logic signed [PROD_W-1:0]   prod_q [NUM_MAC];
    logic signed [PROD_W-1:0]   prod_d [NUM_MAC];
    logic                       prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       in_ready_q, in_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]    data_out_q, data_out_d;

    logic signed [PRE_W-1:0]    pre_c [NUM_MAC];
    logic signed [ACC_W-1:0]    lane_sum_c;
    logic signed [ACC_W-1:0]    acc_sum_c;
    logic                       shift_en_c;
    logic                       line_clr_c;
    logic [DATA_W*TAPS-1:0]     taps_c;

    fir_delay_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_line (
        .clk        (clk),
        .resetn     (resetn),
        .shift_en_i (shift_en_c),
        .clear_i    (line_clr_c),
        .data_i     (data_in_i),
        .taps_o     (taps_c)
    );

    // Lane datapath and FSM next-state: pair k = pass*NUM_MAC + j, mirror tap TAPS-1-k.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        coef_d      = coef_q;
        prod_vld_d  = 1'b0;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        data_out_d  = data_out_q;
        shift_en_c  = 1'b0;
        line_clr_c  = 1'b0;

        lane_sum_c = '0;
        for (int j = 0; j < NUM_MAC; j++) begin
            lane_sum_c = lane_sum_c + ACC_W'(prod_q[j]);
        end
        acc_sum_c = prod_vld_q ? (acc_q + lane_sum_c) : acc_q;

        for (int j = 0; j < NUM_MAC; j++) begin
            pre_c[j]  = PRE_W'($signed(taps_c[(pass_q * NUM_MAC + j) * DATA_W +: DATA_W]))
                      + PRE_W'($signed(taps_c[(TAPS - 1 - (pass_q * NUM_MAC + j)) * DATA_W +: DATA_W]));
            prod_d[j] = PROD_W'(pre_c[j])
                      * PROD_W'($signed(coef_q[(pass_q * NUM_MAC + j) * COEF_W +: COEF_W]));
        end

        case (state_q)
            IDLE, OUT: begin
                if (coef_load_i) begin
                    coef_d = coef_in_i;
                end
                line_clr_c = clear_i;
                if (in_valid_i) begin
                    shift_en_c = 1'b1;
                    pass_d     = '0;
                    acc_d      = '0;
                    state_d    = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                prod_vld_d = 1'b1;
                acc_d      = acc_sum_c;
                if (pass_q == PASS_W'(P - 1)) begin
                    state_d = FLUSH;
                end else begin
                    pass_d = pass_q + PASS_W'(1);
                end
            end
            FLUSH: begin
                acc_d       = acc_sum_c;
                out_valid_d = 1'b1;
                data_out_d  = OUT_W'(sat_round(64'(acc_sum_c), OUT_SHIFT, OUT_W));
                state_d     = OUT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == OUT);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            coef_q      <= COEF_INIT;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            for (int j = 0; j < NUM_MAC; j++) begin
                prod_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            coef_q      <= coef_d;
            prod_vld_q  <= prod_vld_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            for (int j = 0; j < NUM_MAC; j++) begin
                prod_q[j] <= prod_d[j];
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign data_out_o  = data_out_q;

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Self-checking bench for fir_sym_tdm against a direct-form reference of the filter equation.
module tb_fir_sym_tdm;

    localparam int unsigned DATA_W    = 5;
    localparam int unsigned COEF_W    = 6;
    localparam int unsigned TAPS      = 20;
    localparam int unsigned NUM_MAC   = 2;
    localparam int unsigned OUT_W     = 5;
    localparam int unsigned OUT_SHIFT = 9;
    localparam int          H         = TAPS / 2;
    localparam int          P         = H / NUM_MAC;
    localparam int          PERIOD    = P + 2;
    localparam int          CW        = H * COEF_W;

    logic                       clk = 1'b0;
    logic                       resetn = 1'b0;
    logic                       in_valid_i = 1'b0;
    logic                       in_ready_o;
    logic signed [DATA_W-1:0]   data_in_i = '0;
    logic                       clear_i = 1'b0;
    logic                       coef_load_i = 1'b0;
    logic [CW-1:0]              coef_in_i = '0;
    logic                       out_valid_o;
    logic signed [OUT_W-1:0]    data_out_o;

    fir_sym_tdm #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .TAPS      (TAPS),
        .NUM_MAC   (NUM_MAC),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_in_i   (data_in_i),
        .clear_i     (clear_i),
        .coef_load_i (coef_load_i),
        .coef_in_i   (coef_in_i),
        .out_valid_o (out_valid_o),
        .data_out_o  (data_out_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
    } exp_t;

    const int INIT_C [H] = '{0, -1, 0, 2, 2, -2, -5, 0, 12, 24};

    int     mdl_line [TAPS];
    int     mdl_c    [H];
    exp_t   exp_q    [$];
    int     log_out  [$];
    bit     logging;
    int     cyc;
    int     last_acc;
    int     last_out;
    int     tests;
    int     fails;

    logic [CW-1:0] cv_init;
    logic [CW-1:0] cv_31;

    // Reference: y = sum c[k]*(x[n-k] + x[n-TAPS+1+k]), then round-half-up shift and clamp.
    function automatic int model_y();
        int acc;
        int r;
        acc = 0;
        for (int k = 0; k < H; k++) begin
            acc += mdl_c[k] * (mdl_line[k] + mdl_line[TAPS-1-k]);
        end
        r = (OUT_SHIFT == 0) ? acc : ((acc + (1 << (OUT_SHIFT - 1))) >>> OUT_SHIFT);
        if (r > (1 << (OUT_W - 1)) - 1) r = (1 << (OUT_W - 1)) - 1;
        if (r < -(1 << (OUT_W - 1)))    r = -(1 << (OUT_W - 1));
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input int expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) mdl_line[i] = 0;
        for (int k = 0; k < H; k++) mdl_c[k] = INIT_C[k];
        exp_q.delete();
        last_acc = -1;
        last_out = 0;
    endtask

    // One clock: predict handshake, update model, advance, then check outputs.
    task automatic tick(output bit accepted);
        bit rdy;
        bit exp_v;
        rdy = (last_acc < 0) || ((cyc + 1 - last_acc) >= PERIOD);
        chk("in_ready", in_ready_o, int'(rdy));
        accepted = rdy && in_valid_i;
        if (rdy && coef_load_i) begin
            for (int k = 0; k < H; k++) mdl_c[k] = int'($signed(coef_in_i[k*COEF_W +: COEF_W]));
        end
        if (rdy && clear_i) begin
            for (int i = 0; i < TAPS; i++) mdl_line[i] = 0;
        end
        if (accepted) begin
            for (int i = TAPS - 1; i > 0; i--) mdl_line[i] = mdl_line[i-1];
            mdl_line[0] = int'(data_in_i);
            exp_q.push_back('{cyc + 1 + P + 1, model_y()});
            last_acc = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("out_valid", out_valid_o, int'(exp_v));
        if (out_valid_o === 1'b1 && logging) log_out.push_back(int'(data_out_o));
        if (exp_v) begin
            last_out = exp_q[0].val;
            void'(exp_q.pop_front());
        end
        chk("data_out", data_out_o, last_out);
    endtask

    task automatic send(input int d, input bit clr, input bit cl, input logic [CW-1:0] cin);
        bit a;
        a = 1'b0;
        in_valid_i  = 1'b1;
        data_in_i   = DATA_W'(d);
        clear_i     = clr;
        coef_load_i = cl;
        coef_in_i   = cin;
        for (int i = 0; i < 3 * PERIOD && !a; i++) tick(a);
        chk("accept", int'(a), 1);
        clear_i     = 1'b0;
        coef_load_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic drain();
        bit a;
        in_valid_i = 1'b0;
        for (int i = 0; i < 3 * PERIOD && exp_q.size() > 0; i++) tick(a);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        in_valid_i  = 1'b0;
        clear_i     = 1'b0;
        coef_load_i = 1'b0;
        resetn      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_data_out", data_out_o, 0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic impulse_run(input string tag);
        log_out.delete();
        logging = 1'b1;
        send(15, 1'b0, 1'b0, '0);
        for (int i = 0; i < 11; i++) send(0, 1'b0, 1'b0, '0);
        drain();
        logging = 1'b0;
        chk({tag, "_count"}, log_out.size(), 12);
        for (int i = 0; i < log_out.size() && i < 12; i++) begin
            chk(tag, log_out[i], (i == 9 || i == 10) ? 1 : 0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        logging = 1'b0;
        for (int k = 0; k < H; k++) begin
            cv_init[k*COEF_W +: COEF_W] = COEF_W'(INIT_C[k]);
            cv_31[k*COEF_W +: COEF_W]   = COEF_W'(31);
        end

        do_reset();
        idle(2);

        // Impulse response at the earliest accept rate.
        impulse_run("impulse");

        // DC gain and floor rounding of the negative half.
        for (int i = 0; i < 20; i++) send(15, 1'b0, 1'b0, '0);
        drain();
        chk("dc_pos", data_out_o, 2);
        for (int i = 0; i < 20; i++) send(-16, 1'b0, 1'b0, '0);
        drain();
        chk("dc_neg", data_out_o, -2);

        // Saturation with all coefficients at 31.
        send(15, 1'b0, 1'b1, cv_31);
        for (int i = 0; i < 19; i++) send(15, 1'b0, 1'b0, '0);
        drain();
        chk("sat_pos", data_out_o, 15);
        for (int i = 0; i < 20; i++) send(-16, 1'b0, 1'b0, '0);
        drain();
        chk("sat_neg", data_out_o, -16);

        // Random samples, gaps, coefficient loads and clears.
        send(0, 1'b0, 1'b1, cv_init);
        for (int i = 0; i < 40; i++) begin
            logic [CW-1:0] rc;
            rc = CW'({$urandom(), $urandom()});
            send(int'($urandom_range(0, 31)) - 16, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0), rc);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
        end
        drain();
        send(0, 1'b0, 1'b1, cv_init);

        // clear/coef_load while busy must be ignored.
        for (int i = 0; i < 20; i++) send(15, 1'b0, 1'b0, '0);
        send(-16, 1'b0, 1'b0, '0);
        in_valid_i  = 1'b0;
        clear_i     = 1'b1;
        coef_load_i = 1'b1;
        coef_in_i   = cv_31;
        idle(4);
        clear_i     = 1'b0;
        coef_load_i = 1'b0;
        send(15, 1'b0, 1'b0, '0);
        drain();

        // clear coincident with accept on a line of 15s leaves only tap 0 (c[0]=0).
        for (int i = 0; i < 20; i++) send(15, 1'b0, 1'b0, '0);
        send(15, 1'b1, 1'b0, '0);
        drain();
        chk("clear_accept", data_out_o, 0);

        // Reset in the middle of MAC aborts the sample.
        send(15, 1'b0, 1'b1, cv_31);
        idle(2);
        do_reset();
        idle(PERIOD + 2);
        impulse_run("impulse_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
